// File: rtl/sparc_tlu_intr_rcv_pkg.sv
// Shared TLU interrupt-path definitions: vector sizing and the thread-id type.
package sparc_tlu_intr_rcv_pkg;

  localparam int INT_VEC_W = 6;
  localparam int INT_VEC_N = 64;
  localparam int TLU_TID_W = 2;

  typedef logic [TLU_TID_W-1:0] tid_t;

endpackage

// File: rtl/sparc_tlu_penc64.sv
// Combinational 64->6 priority encoder; the highest set bit wins and idx is 0 when vec is empty.
module sparc_tlu_penc64
  import sparc_tlu_intr_rcv_pkg::*;
(
  input  logic [INT_VEC_N-1:0] vec,
  output logic [INT_VEC_W-1:0] idx,
  output logic                 vld
);

  // Ascending scan, so the last (highest) hit overrides the earlier ones.
  always_comb begin
    idx = '0;
    vld = |vec;
    for (int i = 0; i < INT_VEC_N; i++) begin
      if (vec[i]) idx = INT_VEC_W'(i);
    end
  end

endmodule

// File: rtl/sparc_tlu_intr_rcv.sv
// Per-thread interrupt receive register bank: latches decoded arrivals, serves
// highest-vector read-and-clear, and drives per-thread pending levels.
module sparc_tlu_intr_rcv
  import sparc_tlu_intr_rcv_pkg::*;
#(
  parameter int THREADS = 4,
  parameter int TID_W   = 2
)(
  input  logic                 rclk,
  input  logic                 rst,
  input  logic                 int_set_vld,
  input  logic [TID_W-1:0]     int_set_tid,
  input  logic [INT_VEC_N-1:0] int_set_onehot,
  input  logic                 sw_clr_vld,
  input  logic [TID_W-1:0]     sw_clr_tid,
  input  logic [INT_VEC_N-1:0] sw_clr_mask,
  input  logic                 rd_vld,
  input  logic [TID_W-1:0]     rd_tid,
  output logic                 rd_data_vld,
  output logic [INT_VEC_W-1:0] rd_data,
  output logic                 rd_hit,
  output logic [THREADS-1:0]   int_pend
);

  logic [INT_VEC_N-1:0] irr      [THREADS];
  logic [INT_VEC_N-1:0] irr_next [THREADS];
  logic [INT_VEC_N-1:0] rd_irr;
  logic [INT_VEC_N-1:0] rd_sel;
  logic [INT_VEC_W-1:0] rd_idx;
  logic                 rd_any;

  assign rd_irr = irr[rd_tid];

  sparc_tlu_penc64 u_penc (
    .vec (rd_irr),
    .idx (rd_idx),
    .vld (rd_any)
  );

  always_comb begin
    rd_sel = '0;
    if (rd_any) rd_sel[rd_idx] = 1'b1;
  end

  // Set is ORed in after the clears so a same-cycle arrival is never lost.
  always_comb begin
    for (int t = 0; t < THREADS; t++) begin
      irr_next[t] = ({INT_VEC_N{int_set_vld && (int_set_tid == TID_W'(t))}} & int_set_onehot)
                  | (irr[t] & ~(({INT_VEC_N{sw_clr_vld && (sw_clr_tid == TID_W'(t))}} & sw_clr_mask)
                              | ({INT_VEC_N{rd_vld && (rd_tid == TID_W'(t))}} & rd_sel)));
    end
  end

  always_ff @(posedge rclk or posedge rst) begin
    if (rst) begin
      for (int t = 0; t < THREADS; t++) begin
        irr[t]      <= '0;
        int_pend[t] <= 1'b0;
      end
    end else begin
      for (int t = 0; t < THREADS; t++) begin
        irr[t]      <= irr_next[t];
        int_pend[t] <= |irr_next[t];
      end
    end
  end

  // Read results hold their last value between reads.
  always_ff @(posedge rclk or posedge rst) begin
    if (rst) begin
      rd_data_vld <= 1'b0;
      rd_data     <= '0;
      rd_hit      <= 1'b0;
    end else begin
      rd_data_vld <= rd_vld;
      if (rd_vld) begin
        rd_data <= rd_idx;
        rd_hit  <= rd_any;
      end
    end
  end

endmodule
